// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES round sequencer: key-length modes, round counts,
// FSM states and the mode-to-round-count lookup.
package aes_ctrl_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE,
        ERR_DONE
    } state_e;

    function automatic logic [3:0] nr_of_mode(input logic [1:0] mode);
        case (mode)
            MODE_128: return NR_128;
            MODE_192: return NR_192;
            MODE_256: return NR_256;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer_counter.sv
// Loadable 4-bit round-key index counter; steps up for the forward cipher and down
// for the inverse cipher, flagging the last middle round before FINAL.
module aes_round_counter
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       step_i,
    input  logic       down_i,
    input  logic [3:0] nr_i,
    output logic [3:0] cnt_o,
    output logic       last_mid_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i) begin
            cnt_d = down_i ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The index one step before the final-round key, in either direction.
    assign last_mid_o = down_i ? (cnt_q == 4'd1) : (cnt_q == (nr_i - 4'd1));
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// Round sequencer for an iterative AES core shared across 128/192/256-bit key banks.
// Optional illegal-request counter enabled by defining AES_ERR_CNT_EN.
//
// state    | meaning
// IDLE     | waiting for a request
// INIT     | initial AddRoundKey (core_load)
// ROUND    | middle rounds 1..Nr-1 (core_round)
// FINAL    | last round without MixColumns (core_final)
// DONE     | result valid, waiting for out_ready
// ERR_DONE | illegal mode reported, waiting for out_ready
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic                 in_decrypt,
    input  logic                 key_ready,
    output logic [1:0]           key_sel,
    output logic                 core_load,
    output logic                 core_round,
    output logic                 core_final,
    output logic                 core_inv,
    output logic [3:0]           rk_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_e     state_q;
    logic [1:0] key_sel_q;
    logic       core_inv_q;
    logic [3:0] nr_q;
    logic       core_load_q;
    logic       core_round_q;
    logic       core_final_q;
    logic       out_valid_q;
    logic       out_err_q;

    logic       accept;
    logic       cnt_load;
    logic [3:0] cnt_load_val;
    logic       cnt_step;
    logic       last_mid;

    assign in_ready = key_ready & ((state_q == IDLE) |
                                   (((state_q == DONE) | (state_q == ERR_DONE)) & out_ready));
    assign accept   = in_valid & in_ready;

    assign cnt_load     = accept & (in_mode != MODE_ILL);
    assign cnt_load_val = in_decrypt ? nr_of_mode(in_mode) : 4'd0;
    assign cnt_step     = (state_q == INIT) | (state_q == ROUND);

    aes_round_counter u_round_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .step_i     (cnt_step),
        .down_i     (core_inv_q),
        .nr_i       (nr_q),
        .cnt_o      (rk_idx),
        .last_mid_o (last_mid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_sel_q    <= 2'b00;
            core_inv_q   <= 1'b0;
            nr_q         <= 4'd0;
            core_load_q  <= 1'b0;
            core_round_q <= 1'b0;
            core_final_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            core_load_q  <= 1'b0;
            core_round_q <= 1'b0;
            core_final_q <= 1'b0;
            case (state_q)
                INIT: begin
                    state_q      <= ROUND;
                    core_round_q <= 1'b1;
                end
                ROUND: begin
                    if (last_mid) begin
                        state_q      <= FINAL;
                        core_final_q <= 1'b1;
                    end else begin
                        core_round_q <= 1'b1;
                    end
                end
                FINAL: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    out_err_q   <= 1'b0;
                end
                DONE, ERR_DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Acceptance overrides the release above so back-to-back requests chain.
            if (accept) begin
                key_sel_q  <= in_mode;
                core_inv_q <= in_decrypt;
                nr_q       <= nr_of_mode(in_mode);
                if (in_mode == MODE_ILL) begin
                    state_q     <= ERR_DONE;
                    out_valid_q <= 1'b1;
                    out_err_q   <= 1'b1;
                end else begin
                    state_q     <= INIT;
                    core_load_q <= 1'b1;
                end
            end
        end
    end

    assign key_sel    = key_sel_q;
    assign core_inv   = core_inv_q;
    assign core_load  = core_load_q;
    assign core_round = core_round_q;
    assign core_final = core_final_q;
    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;
    assign busy       = (state_q != IDLE);

`ifdef AES_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (accept && (in_mode == MODE_ILL) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed, table-driven bench for aes_round_sequencer; honours AES_ERR_CNT_EN
// when checking err_count.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_mode;
    logic       in_decrypt;
    logic       key_ready;
    logic [1:0] key_sel;
    logic       core_load;
    logic       core_round;
    logic       core_final;
    logic       core_inv;
    logic [3:0] rk_idx;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;
    logic       busy;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_ec = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_decrypt (in_decrypt),
        .key_ready  (key_ready),
        .key_sel    (key_sel),
        .core_load  (core_load),
        .core_round (core_round),
        .core_final (core_final),
        .core_inv   (core_inv),
        .rk_idx     (rk_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_err    (out_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    typedef struct {
        logic [1:0] mode;
        logic       dec;
        int         nr;
        int         hold;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] strobes();
        return {core_load, core_round, core_final};
    endfunction

    // Presents a request at a negedge, checks it is acceptable, lets the accept edge pass.
    task automatic issue(input logic [1:0] mode, input logic dec);
        @(negedge clk);
        in_valid   = 1'b1;
        in_mode    = mode;
        in_decrypt = dec;
        #1;
        chk("in_ready_at_request", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Starts at the negedge after the accept edge; ends in DONE.
    task automatic run_body(input logic [1:0] mode, input logic dec, input int nr);
        chk("init_strobes", strobes(), 3'b100);
        chk("init_rk", rk_idx, dec ? nr : 0);
        chk("key_sel", key_sel, mode);
        chk("core_inv", core_inv, dec);
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_busy", busy, 1'b1);
        in_mode    = ~mode;
        in_decrypt = ~dec;
        for (int r = 1; r < nr; r++) begin
            @(negedge clk);
            chk("round_strobes", strobes(), 3'b010);
            chk("round_rk", rk_idx, dec ? (nr - r) : r);
            chk("round_inv", core_inv, dec);
        end
        @(negedge clk);
        chk("final_strobes", strobes(), 3'b001);
        chk("final_rk", rk_idx, dec ? 0 : nr);
        chk("final_out_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("done_out_valid", out_valid, 1'b1);
        chk("done_out_err", out_err, 1'b0);
        chk("done_strobes", strobes(), 3'b000);
        chk("done_rk_held", rk_idx, dec ? 0 : nr);
        chk("done_key_sel", key_sel, mode);
    endtask

    task automatic hold_and_release(input int hold, input logic exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_out_err", out_err, exp_err);
            chk("hold_strobes", strobes(), 3'b000);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 1'b0);
        chk("release_busy", busy, 1'b0);
        chk("release_out_err", out_err, 1'b0);
    endtask

    task automatic err_request(input logic dec, input int hold);
        issue(2'b11, dec);
        exp_ec++;
        chk("err_out_valid", out_valid, 1'b1);
        chk("err_out_err", out_err, 1'b1);
        chk("err_strobes", strobes(), 3'b000);
        chk("err_busy", busy, 1'b1);
        chk("err_key_sel", key_sel, 2'b11);
        hold_and_release(hold, 1'b1);
    endtask

    function automatic int exp_err_count();
`ifdef AES_ERR_CNT_EN
        return (exp_ec > 255) ? 255 : exp_ec;
`else
        return 0;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mode: 2'b00, dec: 1'b0, nr: 10, hold: 0};
        vecs[1] = '{mode: 2'b10, dec: 1'b1, nr: 14, hold: 2};
        vecs[2] = '{mode: 2'b01, dec: 1'b0, nr: 12, hold: 5};
        vecs[3] = '{mode: 2'b11, dec: 1'b0, nr: 0,  hold: 1};
        vecs[4] = '{mode: 2'b01, dec: 1'b1, nr: 12, hold: 1};
        vecs[5] = '{mode: 2'b00, dec: 1'b1, nr: 10, hold: 0};
        vecs[6] = '{mode: 2'b10, dec: 1'b0, nr: 14, hold: 3};

        reset = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_decrypt = 1'b0;
        key_ready = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_strobes", strobes(), 3'b000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rk", rk_idx, 4'd0);
        chk("rst_key_sel", key_sel, 2'b00);
        chk("rst_core_inv", core_inv, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_in_ready_nokey", in_ready, 1'b0);
        key_ready = 1'b1;
        #1;
        chk("rst_in_ready_key", in_ready, 1'b1);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].mode == 2'b11) begin
                err_request(vecs[v].dec, vecs[v].hold);
            end else begin
                issue(vecs[v].mode, vecs[v].dec);
                run_body(vecs[v].mode, vecs[v].dec, vecs[v].nr);
                hold_and_release(vecs[v].hold, 1'b0);
            end
            chk("err_count", err_count, exp_err_count());
        end

        // Back-to-back accept out of DONE.
        issue(2'b01, 1'b0);
        run_body(2'b01, 1'b0, 12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2b_hold_valid", out_valid, 1'b1);
            chk("b2b_hold_strobes", strobes(), 3'b000);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b00; in_decrypt = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        run_body(2'b00, 1'b1, 10);
        hold_and_release(0, 1'b0);

        // Back-to-back from ERR_DONE into an illegal request again and then a legal one.
        err_request(1'b1, 0);
        issue(2'b11, 1'b0);
        exp_ec++;
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'b10; in_decrypt = 1'b0;
        #1;
        chk("err_b2b_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("err_b2b_out_err", out_err, 1'b0);
        run_body(2'b10, 1'b0, 14);
        hold_and_release(0, 1'b0);
        chk("err_count_b2b", err_count, exp_err_count());

        // key_ready gates acceptance only.
        key_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b00; in_decrypt = 1'b0;
        #1;
        chk("nokey_in_ready", in_ready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("nokey_busy", busy, 1'b0);
            chk("nokey_strobes", strobes(), 3'b000);
        end
        in_valid = 1'b0;
        key_ready = 1'b1;
        issue(2'b00, 1'b0);
        key_ready = 1'b0;
        run_body(2'b00, 1'b0, 10);
        hold_and_release(0, 1'b0);
        key_ready = 1'b1;

        // Reset in the middle of ROUND r=4.
        issue(2'b10, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_reset_round", strobes(), 3'b010);
        chk("pre_reset_rk", rk_idx, 4'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_ec = 0;
        chk("midrst_strobes", strobes(), 3'b000);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rk", rk_idx, 4'd0);
        chk("midrst_core_inv", core_inv, 1'b0);
        chk("midrst_key_sel", key_sel, 2'b00);
        chk("midrst_err_count", err_count, 8'd0);
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_valid", out_valid, 1'b0);
        end
        issue(2'b00, 1'b0);
        run_body(2'b00, 1'b0, 10);
        hold_and_release(1, 1'b0);

`ifdef AES_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            issue(2'b11, 1'b0);
            exp_ec++;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("err_count_saturated", err_count, 8'd255);
`endif
        chk("err_count_final", err_count, exp_err_count());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
